// File: rtl/pipe_stage_skid_if.sv
// Valid/ready stream channel carrying one packed stage payload.
// master drives valid/data and observes ready; slave does the opposite.
interface pipe_stage_skid_if #(
    parameter int WIDTH = 64
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// in_ready is a pure flop output (no combinational path from out_ready).
// Flush is synchronous and squashes both entries; data registers keep their contents.
// Optional feature macro: PIPE_STAGE_PERF_EN adds saturating stall/flush counters.
module pipe_stage_skid #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 flush,
    pipe_stage_skid_if.slave     up,
    pipe_stage_skid_if.master    dn,
    output logic [1:0]           occ
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_data_q, main_data_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;

    logic m_v, s_v, acc, dep;

    // Valid bits are decoded from the state: main holds in ONE/FULL, skid only in FULL,
    // so s_v implies m_v by construction.
    assign m_v = (state_q != ST_EMPTY);
    assign s_v = (state_q == ST_FULL);

    assign up.ready  = ~s_v;
    assign dn.valid  = m_v;
    assign dn.data   = main_data_q;
    assign occ       = {1'b0, m_v} + {1'b0, s_v};

    assign acc = up.valid & ~s_v;
    assign dep = m_v & dn.ready;

    // State and payload registers; reset clears everything so out_data reads 0.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    // Next-state: accept into main (or skid when main is stuck), drain skid into main on departure.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    state_d     = ST_ONE;
                    main_data_d = up.data;
                end
            end
            ST_ONE: begin
                if (acc && dep) begin
                    main_data_d = up.data;
                end else if (acc) begin
                    state_d     = ST_FULL;
                    skid_data_d = up.data;
                end else if (dep) begin
                    state_d     = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (dep) begin
                    state_d     = ST_ONE;
                    main_data_d = skid_data_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush wins over any transfer at the same edge; the offered beat is not captured.
        if (flush) begin
            state_d     = ST_EMPTY;
            main_data_d = main_data_q;
            skid_data_d = skid_data_q;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Counter registers; cleared only by reset, never by flush.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Saturating increments: stalled cycles, and flushes that actually discarded something.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (m_v && !dn.ready && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush && m_v && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, backpressure, flush, single-entry swap,
// and (when PIPE_STAGE_PERF_EN is defined) the counters including saturation at CNT_W=4.
module tb_pipe_stage_skid;
    localparam int W  = 16;
    localparam int CW = 4;

    logic CLK = 1'b0;
    logic nRST;
    logic flush;
    logic [1:0] occ;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall_cnt, flush_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    pipe_stage_skid_if #(.WIDTH(W)) up_if ();
    pipe_stage_skid_if #(.WIDTH(W)) dn_if ();

    pipe_stage_skid #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .flush     (flush),
        .up        (up_if),
        .dn        (dn_if),
        .occ       (occ)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #3;
        @(negedge CLK);
        nRST = 1'b1;
        #1;
    endtask

    initial begin
        nRST = 1'b0; flush = 1'b0;
        up_if.valid = 1'b0; up_if.data = '0; dn_if.ready = 1'b0;
        #2;
        // Reset state
        chk("rst_out_valid", 64'(dn_if.valid), 64'd0);
        chk("rst_in_ready",  64'(up_if.ready), 64'd1);
        chk("rst_occ",       64'(occ),         64'd0);
        chk("rst_out_data",  64'(dn_if.data),  64'd0);
        do_reset();

        // Streaming 1..8 with 1-cycle latency
        dn_if.ready = 1'b1;
        up_if.valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            up_if.data = W'(i);
            tick();
            chk($sformatf("strm_data_%0d", i), 64'(dn_if.data),  64'(i));
            chk($sformatf("strm_vld_%0d", i),  64'(dn_if.valid), 64'd1);
            chk($sformatf("strm_rdy_%0d", i),  64'(up_if.ready), 64'd1);
        end
        up_if.valid = 1'b0;
        tick();
        chk("strm_drain_occ", 64'(occ), 64'd0);

        // Backpressure: A,B,C with out_ready=0
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1; up_if.data = 16'h000A;
        tick();
        chk("bp_occ_a",   64'(occ),         64'd1);
        chk("bp_rdy_a",   64'(up_if.ready), 64'd1);
        up_if.data = 16'h000B;
        tick();
        chk("bp_occ_b",   64'(occ),         64'd2);
        chk("bp_rdy_b",   64'(up_if.ready), 64'd0);
        chk("bp_data_ab", 64'(dn_if.data),  64'h000A);
        up_if.data = 16'h000C;
        tick();
        chk("bp_hold_occ",  64'(occ),        64'd2);
        chk("bp_hold_data", 64'(dn_if.data), 64'h000A);
        dn_if.ready = 1'b1;
        tick();
        chk("bp_out_b",  64'(dn_if.data),  64'h000B);
        chk("bp_occ_b1", 64'(occ),         64'd1);
        chk("bp_rdy_b1", 64'(up_if.ready), 64'd1);
        tick();
        chk("bp_out_c",  64'(dn_if.data), 64'h000C);
        chk("bp_occ_c",  64'(occ),        64'd1);
        up_if.valid = 1'b0;
        tick();
        chk("bp_empty",  64'(occ), 64'd0);

        // Flush priority over acc and dep
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1; up_if.data = 16'h0011; tick();
        up_if.data = 16'h0022; tick();
        chk("fl_pre_occ", 64'(occ), 64'd2);
        flush = 1'b1; up_if.data = 16'h0033; dn_if.ready = 1'b1;
        tick();
        chk("fl_occ",   64'(occ),         64'd0);
        chk("fl_vld",   64'(dn_if.valid), 64'd0);
        chk("fl_rdy",   64'(up_if.ready), 64'd1);
        flush = 1'b0; up_if.valid = 1'b0;
        tick();
        chk("fl_nocap", 64'(occ), 64'd0);

        // Single-entry simultaneous accept and depart
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1; up_if.data = 16'h0044; tick();
        chk("se_occ0", 64'(occ), 64'd1);
        up_if.data = 16'h0055; dn_if.ready = 1'b1; tick();
        chk("se_occ1", 64'(occ),        64'd1);
        chk("se_data", 64'(dn_if.data), 64'h0055);
        up_if.valid = 1'b0; tick();

        // Async reset mid-stream with occ=2
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1; up_if.data = 16'h0066; tick();
        up_if.data = 16'h0077; tick();
        up_if.valid = 1'b0;
        chk("mr_pre_occ", 64'(occ), 64'd2);
        #2;
        nRST = 1'b0;
        #1;
        chk("mr_vld",  64'(dn_if.valid), 64'd0);
        chk("mr_rdy",  64'(up_if.ready), 64'd1);
        chk("mr_occ",  64'(occ),         64'd0);
        chk("mr_data", 64'(dn_if.data),  64'd0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;

`ifdef PIPE_STAGE_PERF_EN
        do_reset();
        chk("pf_rst_stall", 64'(stall_cnt), 64'd0);
        chk("pf_rst_flush", 64'(flush_cnt), 64'd0);
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1; up_if.data = 16'h0088; tick();
        up_if.valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("pf_stall5", 64'(stall_cnt), 64'd5);
        flush = 1'b1; dn_if.ready = 1'b1; tick();
        chk("pf_flush1", 64'(flush_cnt), 64'd1);
        tick();
        flush = 1'b0;
        chk("pf_flush_empty", 64'(flush_cnt), 64'd1);
        chk("pf_stall_kept",  64'(stall_cnt), 64'd5);
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1; up_if.data = 16'h0099; tick();
        up_if.valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("pf_stall_sat", 64'(stall_cnt), 64'd15);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
